// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus bundle: PC handshake, instruction-memory port and
// decode-queue head, shared between the fetch stage and its environment.
interface instr_fetch_if;
  logic [31:0] pc_in;
  logic        pc_hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;
  logic        id_ready;

  modport slave (
    input  pc_in, imem_rvalid, imem_rdata, flush, id_ready,
    output pc_hold, imem_req, imem_addr, id_valid, id_instr, id_pc, id_fault
  );

  modport master (
    output pc_in, imem_rvalid, imem_rdata, flush, id_ready,
    input  pc_hold, imem_req, imem_addr, id_valid, id_instr, id_pc, id_fault
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32 instruction-fetch stage: one outstanding word request at a time,
// returned words (or misaligned-PC fault entries) queued for decode.
module instr_fetch #(
  parameter int unsigned DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]      r_q_instr [DEPTH];
  logic [31:0]      r_q_pc    [DEPTH];
  logic [DEPTH-1:0] r_q_fault;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pc_lat;

  logic        w_full;
  logic        w_issue;
  logic        w_fault_push;
  logic        w_resp_push;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_push_instr;
  logic [31:0] w_push_pc;

  assign w_full = (r_count == CNT_W'(DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a flush while waiting turns the pending response into one to drop
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid)  w_next_state = S_IDLE;
        else if (bus.flush)   w_next_state = S_DROP;
      end
      S_DROP: begin
        if (bus.imem_rvalid)  w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output / control decode; full check uses the registered count only
  always_comb begin
    w_issue      = 1'b0;
    w_fault_push = 1'b0;
    w_resp_push  = 1'b0;
    w_pop        = 1'b0;
    if (!rst) begin
      if (r_state == S_IDLE && !bus.flush && !w_full) begin
        if (bus.pc_in[1:0] == 2'b00) w_issue      = 1'b1;
        else                         w_fault_push = 1'b1;
      end
      if (r_state == S_WAIT && bus.imem_rvalid && !bus.flush) w_resp_push = 1'b1;
      w_pop = (r_count != '0) && bus.id_ready && !bus.flush;
    end
    w_push       = w_fault_push | w_resp_push;
    w_push_instr = w_fault_push ? '0 : bus.imem_rdata;
    w_push_pc    = w_fault_push ? bus.pc_in : r_pc_lat;
  end

  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = bus.pc_in;
  assign bus.pc_hold   = rst | ~(bus.flush | w_issue | w_fault_push);
  assign bus.id_valid  = ~rst & (r_count != '0);
  assign bus.id_instr  = r_q_instr[r_rptr];
  assign bus.id_pc     = r_q_pc[r_rptr];
  assign bus.id_fault  = r_q_fault[r_rptr];

  always_ff @(posedge clk) begin
    if (w_issue) r_pc_lat <= bus.pc_in;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wptr] <= w_push_instr;
      r_q_pc[r_wptr]    <= w_push_pc;
      r_q_fault[r_wptr] <= w_fault_push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, all checked
// against a queue-based reference of the fetch stage.
module tb_instr_fetch;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  entry_t      mq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  bit          m_inflight = 0;
  bit          m_discard  = 0;
  logic [31:0] m_lat = '0;
  logic [31:0] pc_reg = '0;
  bit          mem_busy = 0;
  int unsigned mem_due = 0;
  logic [31:0] mem_addr = '0;
  int unsigned k_lat = 1;
  int unsigned spur_pct = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit rst_i, input bit flush_i, input bit ready_i,
                      input logic [31:0] target);
    bit          rv;
    bit          ex_issue;
    bit          ex_fpush;
    bit          ex_hold;
    bit          ex_valid;
    logic [31:0] pc_old;
    logic [31:0] rdata;
    entry_t      e;

    rv = mem_busy && (mem_due == cyc);
    if (!mem_busy && spur_pct != 0 && $urandom_range(99) < spur_pct) rv = 1'b1;
    rdata = (rv && mem_busy && mem_addr == 32'h0) ? 32'h0050_0093 : $urandom;
    rst             = rst_i;
    bus.flush       = flush_i;
    bus.id_ready    = ready_i;
    bus.pc_in       = pc_reg;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rdata;
    pc_old          = pc_reg;

    @(negedge clk);
    ex_issue = 1'b0;
    ex_fpush = 1'b0;
    if (!rst_i && !m_inflight && !flush_i && mq.size() < DEPTH) begin
      if (pc_old[1:0] == 2'b00) ex_issue = 1'b1;
      else                      ex_fpush = 1'b1;
    end
    ex_hold  = rst_i || !(flush_i || ex_issue || ex_fpush);
    ex_valid = !rst_i && (mq.size() != 0);

    check("imem_req", 32'(bus.imem_req), 32'(ex_issue));
    if (ex_issue) check("imem_addr", bus.imem_addr, pc_old);
    check("pc_hold", 32'(bus.pc_hold), 32'(ex_hold));
    check("id_valid", 32'(bus.id_valid), 32'(ex_valid));
    if (ex_valid) begin
      check("id_instr", bus.id_instr, mq[0].instr);
      check("id_pc", bus.id_pc, mq[0].pc);
      check("id_fault", 32'(bus.id_fault), 32'(mq[0].fault));
    end

    if (rv) mem_busy = 1'b0;
    if (bus.imem_req === 1'b1) begin
      mem_busy = 1'b1;
      mem_due  = cyc + k_lat;
      mem_addr = bus.imem_addr;
    end
    if (rst_i)                      pc_reg = '0;
    else if (bus.pc_hold === 1'b0)  pc_reg = flush_i ? target : pc_reg + 32'd4;

    if (rst_i) begin
      mq.delete();
      m_inflight = 1'b0;
      m_discard  = 1'b0;
    end else begin
      if (flush_i)                 mq.delete();
      else if (ex_valid && ready_i) mq.delete(0);
      if (m_inflight) begin
        if (rv) begin
          if (!m_discard && !flush_i) begin
            e = '{instr: rdata, pc: m_lat, fault: 1'b0};
            mq.push_back(e);
          end
          m_inflight = 1'b0;
          m_discard  = 1'b0;
        end else if (flush_i) begin
          m_discard = 1'b1;
        end
      end
      if (ex_issue) begin
        m_inflight = 1'b1;
        m_lat      = pc_old;
      end
      if (ex_fpush) begin
        e = '{instr: 32'h0, pc: pc_old, fault: 1'b1};
        mq.push_back(e);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_inflight();
    for (int i = 0; i < 40 && m_inflight; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    bit          fl;
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.id_ready    = 1'b0;
    bus.pc_in       = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    @(posedge clk);
    #1;

    // Reset release, k=1, first word at 0x0
    k_lat = 1;
    repeat (3) step(1'b1, 1'b0, 1'b1, 32'h0);
    repeat (6) step(1'b0, 1'b0, 1'b1, 32'h0);

    // Decode stalled: queue fills, then drains in order
    repeat (2)  step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (8)  step(1'b0, 1'b0, 1'b1, 32'h0);

    // Flush during a k=3 wait at 0x10, redirect to 0x100
    k_lat = 3;
    drain_inflight();
    step(1'b0, 1'b1, 1'b1, 32'h10);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    repeat (12) step(1'b0, 1'b0, 1'b1, 32'h0);

    // Flush coincident with response and a pop at count=1
    k_lat = 2;
    drain_inflight();
    step(1'b0, 1'b1, 1'b0, 32'h20);
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 1 && m_inflight && mem_busy && mem_due == cyc) begin
        step(1'b0, 1'b1, 1'b1, 32'h300);
        break;
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
    end
    repeat (6) step(1'b0, 1'b0, 1'b1, 32'h0);

    // Misaligned PC produces fault entries
    drain_inflight();
    step(1'b0, 1'b1, 1'b1, 32'h6);
    repeat (4) step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h200);
    repeat (4) step(1'b0, 1'b0, 1'b1, 32'h0);

    // Reset while a response is pending
    k_lat = 3;
    for (int i = 0; i < 40 && !m_inflight; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
    repeat (5) step(1'b1, 1'b0, 1'b1, 32'h0);
    repeat (8) step(1'b0, 1'b0, 1'b1, 32'h0);

    // Random traffic with spurious responses while idle
    spur_pct = 5;
    for (int i = 0; i < 400; i++) begin
      k_lat = $urandom_range(4, 1);
      fl    = ($urandom_range(99) < 8);
      tgt   = $urandom & 32'h0000_FFFC;
      if ($urandom_range(9) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
      step(1'b0, fl, ($urandom_range(99) < 60), tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
